// File: rtl/f32m_sub4_pkg.sv
`default_nettype none
// ============================================================================
// Module   : f32m_sub4_pkg
// Brief    : Field sizes, GF(3) digit encodings, FSM states and digit adder
//            shared by the GF(3^2m) four-operand subtractor.
// Revision : 1.0 - initial release
// ============================================================================
package f32m_sub4_pkg;

    localparam int M     = 97;
    localparam int WIDTH = 2*M - 1;
    localparam int W2    = 4*M - 1;

    localparam logic [1:0] ZERO    = 2'b00;
    localparam logic [1:0] ONE     = 2'b01;
    localparam logic [1:0] TWO     = 2'b10;
    localparam logic [1:0] ILLEGAL = 2'b11;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SUB2 = 2'd1;
    localparam logic [1:0] SUB3 = 2'd2;

    // Mod-3 digit add; any illegal operand collapses to zero.
    function automatic logic [1:0] gf3_add(input logic [1:0] x, input logic [1:0] y);
        logic [1:0] r;
        r = ZERO;
        case ({x, y})
            {ZERO, ZERO}: r = ZERO;
            {ZERO, ONE }: r = ONE;
            {ZERO, TWO }: r = TWO;
            {ONE,  ZERO}: r = ONE;
            {ONE,  ONE }: r = TWO;
            {ONE,  TWO }: r = ZERO;
            {TWO,  ZERO}: r = TWO;
            {TWO,  ONE }: r = ZERO;
            {TWO,  TWO }: r = ONE;
            default:      r = ZERO;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/f32m_sub.sv
`default_nettype none
// ============================================================================
// Module   : f32m_sub
// Brief    : Combinational GF(3^2m) subtract, o_diff = i_a - i_b, digit-wise.
// Revision : 1.0 - initial release
// ============================================================================
module f32m_sub
    import f32m_sub4_pkg::*;
(
    input  logic [W2:0] i_a,
    input  logic [W2:0] i_b,
    output logic [W2:0] o_diff
);

    // Negating a digit swaps its two bits; both halves share the same rule.
    for (genvar i = 0; i < 2*M; i++) begin : g_digit
        assign o_diff[2*i+1:2*i] = gf3_add(i_a[2*i+1:2*i], {i_b[2*i], i_b[2*i+1]});
    end

endmodule
`default_nettype wire

// File: rtl/f32m_sub4.sv
`default_nettype none
// ============================================================================
// Module   : f32m_sub4
// Brief    : Sequential c = a0 - a1 - a2 - a3 over GF(3^2m) on one shared
//            subtractor, three cycles per result, start/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module f32m_sub4
    import f32m_sub4_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [W2:0] a0,
    input  logic [W2:0] a1,
    input  logic [W2:0] a2,
    input  logic [W2:0] a3,
    output logic [W2:0] c,
    output logic        done,
    output logic        busy
);

    logic [1:0]  r_state;
    logic [W2:0] r_acc;
    logic [W2:0] r_r2;
    logic [W2:0] r_r3;
    logic [W2:0] r_c;
    logic        r_done;
    logic [W2:0] w_x;
    logic [W2:0] w_y;
    logic [W2:0] w_diff;

    always_comb begin
        w_x = a0;
        w_y = a1;
        case (r_state)
            SUB2: begin
                w_x = r_acc;
                w_y = r_r2;
            end
            SUB3: begin
                w_x = r_acc;
                w_y = r_r3;
            end
            default: begin
                w_x = a0;
                w_y = a1;
            end
        endcase
    end

    f32m_sub u_sub (
        .i_a    (w_x),
        .i_b    (w_y),
        .o_diff (w_diff)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_r2    <= '0;
            r_r3    <= '0;
            r_c     <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc   <= w_diff;
                        r_r2    <= a2;
                        r_r3    <= a3;
                        r_state <= SUB2;
                    end
                end
                SUB2: begin
                    r_acc   <= w_diff;
                    r_state <= SUB3;
                end
                SUB3: begin
                    r_c     <= w_diff;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign c    = r_c;
    assign done = r_done;
    assign busy = (r_state != IDLE);

endmodule
`default_nettype wire

// File: doc/f32m_sub4.md
# f32m_sub4

Sequential four-operand subtractor over GF(3^{2m}). It computes c = a0 − a1 − a2 − a3 using one shared GF(3^{2m}) subtract datapath over three cycles, under a start/done handshake. It is the inverse-direction companion to the combinational GF(3^{2m}) adder tree. Pairing-datapath controllers use it to undo accumulated sums; a narrow single subtractor replaces three parallel 388-bit instances.

## Interface
Parameters (shared package constants, not per-instance):
- M, 97, degree of the irreducible polynomial
- WIDTH, 2*M−1, MSB index of a GF(3^m) element (194 bits)
- W2, 4*M−1, MSB index of a GF(3^{2m}) element (388 bits)

Ports:
- clk  input  1  rising-edge clock; single clock domain
- reset  input  1  synchronous, active-low (reset==0 at a clk edge resets)
- start  input  1  request; sampled only in IDLE
- a0, a1, a2, a3  input  W2+1  operands; valid only in the start cycle
- c  output  W2+1  result; registered, held until the next completion
- done  output  1  one-cycle pulse, c valid
- busy  output  1  high while an operation is in flight

## Operation
- Digit encoding: each GF(3) digit is 2 bits {hi,lo}: 00=0, 01=1, 10=2. 11 is illegal.
- Element layout: GF(3^m) digit i occupies bits [2i+1:2i]. A GF(3^{2m}) element is {high half [W2:WIDTH+1], low half [WIDTH:0]}. The two halves are processed independently.
- Digit negation is a bit swap: −{h,l} = {l,h}. Digit subtraction x − y = x + (−y) mod 3.
- Any digit pair where either x or y is 11 yields 00. Negation maps 11 to 11, so this holds at every step.
- FSM states are IDLE, SUB2, SUB3.
- IDLE with start=1:
  - acc ← a0 − a1, computed from the input ports.
  - r2 ← a2, r3 ← a3.
  - Next state is SUB2.
- SUB2: acc ← acc − r2. Next state is SUB3.
- SUB3:
  - c ← acc − r3.
  - done ← 1.
  - Next state is IDLE.
- IDLE with start=0: all registers hold and done ← 0.
- Only one subtract datapath exists. Its operand mux selects (a0, a1) in IDLE, (acc, r2) in SUB2 and (acc, r3) in SUB3.
- busy = (state != IDLE).

## Timing
- Reset values: state=IDLE, c=0, done=0, busy=0. acc, r2 and r3 are cleared to 0.
- Latency: start is sampled at edge k. done=1 and c valid in the cycle after edge k+2, which is three cycles after start was asserted.
- done is high for exactly one cycle. c holds its value until the next SUB3 edge or reset.
- start while busy=1 is ignored and has no effect on the in-flight result. It is not queued.
- start in the cycle where done=1 is accepted, because state is IDLE then. Back-to-back throughput is one result per 3 cycles.
- Reset asserted mid-operation aborts the operation:
  - The next state is IDLE.
  - done is not pulsed.
  - c is cleared to 0.
- Reset has priority over start in the same cycle.
- Operands a0..a3 need not remain stable after the start cycle.

## Structure
- Shared package holds:
  - M, WIDTH, W2
  - the digit encodings ZERO, ONE, TWO, ILLEGAL
  - the FSM state encoding
- One natural sub-module is f32m_sub. It is a combinational GF(3^{2m}) subtract that swaps each digit pair of b, then applies the existing per-digit GF(3) add.
- f32m_sub4 contains only the FSM, the operand mux, the acc/r2/r3 registers and the output register.

## Test plan
- All operands 0, start → done exactly 3 cycles later, c=0, busy high for 2 cycles.
- a0 = every digit 01, a1=a2=a3=0 → c = every digit 01, in both halves.
- a0=0, a1 = digit 0 of low half = 01, others 0, a2=a3=0 → c digit 0 = 10, all other digits 00.
- a0=0, a1=a2=a3 = every digit 01 → c=0, since −3 ≡ 0. Also a0 = every digit 10, a1 = every digit 01, a2=a3=0 → c = every digit 01.
- Illegal digit: a2 digit 5 = 11 and everything else 0 → c digit 5 = 00, and no X propagates.
- Control cases:
  - Second start pulsed in SUB2 is ignored; done pulses once.
  - start in the done cycle produces a second done 3 cycles later.
  - reset=0 in SUB3 → no done pulse, c=0, busy=0 next cycle.
